// File: rtl/alu_driver_if.sv
// Bundled command, ALU and result signals between alu_driver and its environment.
// clk/rst stay as plain ports on the modules.
interface alu_driver_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_in_valid;
  logic [WIDTH-1:0] alu_out;
  logic             alu_out_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             err;

  modport master (
    input  cmd_op, cmd_a, cmd_b, cmd_valid, alu_out, alu_out_valid, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, alu_in_valid, res_data, res_valid, busy, err
  );

  modport slave (
    output cmd_op, cmd_a, cmd_b, cmd_valid, alu_out, alu_out_valid, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, alu_in_valid, res_data, res_valid, busy, err
  );
endinterface

// File: rtl/alu_driver.sv
// Credit-based initiator for the fixed-latency registered ALU; results are
// buffered in an in-order FIFO that always has room for every issued op.
module alu_driver #(
  parameter int WIDTH     = 4,
  parameter int RES_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  alu_driver_if.master bus
);
  localparam int unsigned PW = $clog2(RES_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [RES_DEPTH];
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             iv_q;
  logic             err_q, err_d;

  logic accept, pop, push, empty, full;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
             (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    accept = bus.cmd_valid && (credits_q != '0);
    pop    = !empty && bus.res_ready;
    push   = bus.alu_out_valid && (inflight_q != '0) && (!full || pop);

    credits_d  = credits_q - CW'(accept) + CW'(pop);
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    wr_ptr_d   = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
    err_d      = err_q || (bus.alu_out_valid && !push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= CW'(RES_DEPTH);
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      iv_q       <= 1'b0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      iv_q       <= accept;
      if (accept) begin
        op_q <= bus.cmd_op;
        a_q  <= bus.cmd_a;
        b_q  <= bus.cmd_b;
      end
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= bus.alu_out;
    end
  end

  always_comb begin
    bus.cmd_ready    = (credits_q != '0);
    bus.alu_op       = op_q;
    bus.alu_a        = a_q;
    bus.alu_b        = b_q;
    bus.alu_in_valid = iv_q;
    bus.res_data     = mem_q[rd_ptr_q[PW-1:0]];
    bus.res_valid    = !empty;
    bus.busy         = (inflight_q != '0) || !empty;
    bus.err          = err_q;
  end
endmodule
